// File: rtl/render_pkg.sv
// Shared render-path types: framebuffer defaults, coordinate/colour widths, pixel FIFO entry.
package render_pkg;

    localparam int FB_WIDTH_DEF  = 1920;
    localparam int FB_HEIGHT_DEF = 1080;
    localparam int X_W           = 11;
    localparam int Y_W           = 12;
    localparam int COLOR_W       = 32;

    // nowrite marks a clipped end-of-frame pixel kept only to carry frame ordering
    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic               last;
        logic               nowrite;
    } pix_entry_t;

    typedef enum logic {S_IDLE, S_WRITE} wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Purpose: synchronous FIFO with registered storage and full/empty flags.
// Latency: a push is visible at rd_dat the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty.
module pixel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("pixel_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [W-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/pixel_writer.sv
// Purpose: clip incoming pixels, queue them, and issue framebuffer word writes.
// Latency: 2 cycles from accept to mem_wr_en on an idle block; one write per cycle sustained.
// Backpressure: in_ready = FIFO not full; mem_addr/mem_data hold until mem_wr_ready.
module pixel_writer
    import render_pkg::*;
#(
    parameter int FB_WIDTH   = FB_WIDTH_DEF,
    parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_W-1:0]     in_x,
    input  logic [Y_W-1:0]     in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_last,
    output logic               mem_wr_en,
    input  logic               mem_wr_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               frame_done,
    output logic [15:0]        clip_count,
    output logic               busy
);
    generate
        if (64'(FB_WIDTH) * 64'(FB_HEIGHT) > (64'd1 << ADDR_W)) begin : g_addr_chk
            $error("pixel_writer: FB_WIDTH*FB_HEIGHT does not fit in ADDR_W");
        end
    endgenerate

    pix_entry_t        in_ent;
    pix_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rdy_q;
    logic              acc;
    logic              clipped;
    logic              push;
    logic              pop;
    logic              last_q;
    wr_state_t         state;
    logic [ADDR_W-1:0] head_addr;

    // rdy_q keeps in_ready low through reset and for the first cycle out of it
    assign in_ready = rdy_q & ~rst & ~fifo_full;
    assign acc      = in_valid & in_ready;
    assign clipped  = (32'(in_x) >= FB_WIDTH) || (32'(in_y) >= FB_HEIGHT);
    assign push     = acc & (~clipped | in_last);
    assign pop      = ~fifo_empty & ((state == S_IDLE) | mem_wr_ready);
    assign busy     = ~fifo_empty | (state == S_WRITE);

    always_comb begin
        in_ent         = '0;
        in_ent.x       = in_x;
        in_ent.y       = in_y;
        in_ent.color   = in_color;
        in_ent.last    = in_last;
        in_ent.nowrite = clipped;
    end

    assign head_addr = ADDR_W'(64'(head.y) * 64'(FB_WIDTH) + 64'(head.x));

    pixel_fifo #(
        .W     ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (in_ent),
        .pop    (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rdy_q      <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
            clip_count <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (acc && clipped && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
            // A completing last write and a popped end marker both close a frame
            frame_done <= (state == S_WRITE && mem_wr_ready && last_q) || (pop && head.nowrite);
            if (pop) begin
                if (head.nowrite) begin
                    state     <= S_IDLE;
                    mem_wr_en <= 1'b0;
                    last_q    <= 1'b0;
                end else begin
                    state     <= S_WRITE;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= head_addr;
                    mem_data  <= head.color;
                    last_q    <= head.last;
                end
            end else if (state == S_WRITE && mem_wr_ready) begin
                state     <= S_IDLE;
                mem_wr_en <= 1'b0;
                last_q    <= 1'b0;
            end
        end
    end

endmodule
